// File: rtl/i2s_receiver.sv
// i2s_receiver
//   Receives a standard (Philips) I2S stereo stream sampled in the clk domain.
//   SCK, WS and SD are synchronised, SCK rising edges are detected, and each
//   completed left/right pair is presented as one sample_valid pulse.
//
// Parameters
//   SAMPLE_BITS    : word width per channel (8..32)
//   TIMEOUT_CYCLES : clk cycles without an SCK rise before the link is lost
//
// Ports
//   clk           : system clock
//   nrst          : asynchronous active-low reset
//   i2s_sck       : I2S bit clock (asynchronous)
//   i2s_ws        : I2S word select, 0 = left, 1 = right (asynchronous)
//   i2s_sd        : I2S serial data, MSB first (asynchronous)
//   sample_left   : last left word, LSB-aligned, upper bits zero
//   sample_right  : last right word, LSB-aligned, upper bits zero
//   sample_valid  : one-clk pulse when a new pair is presented
//   frame_error   : one-clk pulse when a completed word was short
//   sck_lost      : high while the link is declared lost
//   busy          : high while locked onto the stream (S_RECV)
module i2s_receiver #(
  parameter int SAMPLE_BITS    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i2s_sck,
  input  logic        i2s_ws,
  input  logic        i2s_sd,
  output logic [31:0] sample_left,
  output logic [31:0] sample_right,
  output logic        sample_valid,
  output logic        frame_error,
  output logic        sck_lost,
  output logic        busy
);

  typedef enum logic {S_IDLE = 1'b0, S_RECV = 1'b1} state_t;

  localparam logic [5:0]  SB_CNT  = 6'(SAMPLE_BITS);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TO_DONE = 16'(TIMEOUT_CYCLES);

  // [0]/[1] form the synchroniser, [2] is the delayed copy for edge detect
  logic [2:0]             sck_sync_reg;
  logic [1:0]             ws_sync_reg;
  logic [1:0]             sd_sync_reg;
  state_t                 state_reg;
  logic                   ws_d_reg;
  logic [SAMPLE_BITS-1:0] shift_reg;
  logic [SAMPLE_BITS-1:0] pend_left_reg;
  logic [SAMPLE_BITS-1:0] left_reg;
  logic [SAMPLE_BITS-1:0] right_reg;
  logic                   left_pending_reg;
  logic [5:0]             bit_cnt_reg;
  logic [15:0]            to_cnt_reg;

  logic                   sck_rise;
  logic                   ws_s;
  logic                   sd_s;
  logic [SAMPLE_BITS-1:0] shift_next;
  logic [SAMPLE_BITS-1:0] word_done;
  logic [5:0]             cnt_next;
  logic [5:0]             pad;
  logic                   short_word;
  logic                   ws_edge;
  logic                   timeout_hit;

  assign sck_rise = sck_sync_reg[1] & ~sck_sync_reg[2];
  assign ws_s     = ws_sync_reg[1];
  assign sd_s     = sd_sync_reg[1];

  assign sample_left  = 32'(left_reg);
  assign sample_right = 32'(right_reg);

  always_comb begin
    // Bits beyond SAMPLE_BITS are counted but never shifted in, so the word
    // keeps the first SAMPLE_BITS bits of the slot.
    shift_next  = (bit_cnt_reg < SB_CNT) ? {shift_reg[SAMPLE_BITS-2:0], sd_s} : shift_reg;
    cnt_next    = (bit_cnt_reg == 6'd63) ? bit_cnt_reg : bit_cnt_reg + 6'd1;
    short_word  = (cnt_next < SB_CNT);
    // A short word is MSB-justified by padding zeros below it.
    pad         = short_word ? (SB_CNT - cnt_next) : 6'd0;
    word_done   = shift_next << pad;
    ws_edge     = ws_s ^ ws_d_reg;
    timeout_hit = (to_cnt_reg == TO_LAST);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_sync_reg     <= '0;
      ws_sync_reg      <= '0;
      sd_sync_reg      <= '0;
      state_reg        <= S_IDLE;
      ws_d_reg         <= 1'b0;
      shift_reg        <= '0;
      pend_left_reg    <= '0;
      left_reg         <= '0;
      right_reg        <= '0;
      left_pending_reg <= 1'b0;
      bit_cnt_reg      <= '0;
      to_cnt_reg       <= '0;
      sample_valid     <= 1'b0;
      frame_error      <= 1'b0;
      sck_lost         <= 1'b0;
      busy             <= 1'b0;
    end else begin
      sck_sync_reg <= {sck_sync_reg[1:0], i2s_sck};
      ws_sync_reg  <= {ws_sync_reg[0], i2s_ws};
      sd_sync_reg  <= {sd_sync_reg[0], i2s_sd};
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;

      if (sck_rise) begin
        // An SCK rise always wins over a coincident timeout.
        to_cnt_reg <= '0;
        sck_lost   <= 1'b0;
        ws_d_reg   <= ws_s;
        if (state_reg == S_IDLE) begin
          // Lock on the first WS transition; the partial word is dropped.
          if (ws_edge) begin
            state_reg   <= S_RECV;
            busy        <= 1'b1;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
          end
        end else if (!ws_edge) begin
          shift_reg   <= shift_next;
          bit_cnt_reg <= cnt_next;
        end else begin
          // WS changed: this bit is the last one of channel ws_d.
          shift_reg   <= '0;
          bit_cnt_reg <= '0;
          frame_error <= short_word;
          if (!ws_d_reg) begin
            pend_left_reg    <= word_done;
            left_pending_reg <= 1'b1;
          end else if (left_pending_reg) begin
            left_reg         <= pend_left_reg;
            right_reg        <= word_done;
            sample_valid     <= 1'b1;
            left_pending_reg <= 1'b0;
          end
        end
      end else if (timeout_hit) begin
        sck_lost         <= 1'b1;
        state_reg        <= S_IDLE;
        busy             <= 1'b0;
        left_pending_reg <= 1'b0;
        shift_reg        <= '0;
        bit_cnt_reg      <= '0;
        to_cnt_reg       <= TO_DONE;
      end else if (to_cnt_reg != TO_DONE) begin
        // Parks at TO_DONE so a dead link reports the loss only once.
        to_cnt_reg <= to_cnt_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Testbench for i2s_receiver: two instances (16-bit and 24-bit words) share
// the same I2S pins and are checked every cycle against a stream-level model,
// plus literal expectations after each directed phase.
module tb_i2s_receiver;

  localparam int T_OUT = 1024;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic sck  = 1'b0;
  logic ws   = 1'b0;
  logic sd   = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] sl [2];
  logic [31:0] sr [2];
  logic        sv [2];
  logic        fe [2];
  logic        lst[2];
  logic        bsy[2];

  i2s_receiver #(.SAMPLE_BITS(16), .TIMEOUT_CYCLES(T_OUT)) u_dut16 (
    .clk(clk), .nrst(nrst), .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd),
    .sample_left(sl[0]), .sample_right(sr[0]), .sample_valid(sv[0]),
    .frame_error(fe[0]), .sck_lost(lst[0]), .busy(bsy[0])
  );

  i2s_receiver #(.SAMPLE_BITS(24), .TIMEOUT_CYCLES(T_OUT)) u_dut24 (
    .clk(clk), .nrst(nrst), .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd),
    .sample_left(sl[1]), .sample_right(sr[1]), .sample_valid(sv[1]),
    .frame_error(fe[1]), .sck_lost(lst[1]), .busy(bsy[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s[dut%0d] cyc %0d: got %h, expected %h", name, inst, cyc, act, exp);
    end
  endtask

  // ---------------- stream-level model ----------------
  typedef struct {
    int   c;
    logic w;
    logic d;
  } rise_t;
  rise_t rq[$];

  int              sbv[2] = '{16, 24};
  longint unsigned m_all[2];   // every data bit of the current word, in order
  int              m_n[2];
  bit              m_recv[2], m_wsd[2], m_pend[2], m_val[2], m_fe[2], m_lost[2];
  logic [31:0]     m_pl[2], m_l[2], m_r[2];
  int              last_clear = 0;
  bit              in_rst = 1'b1;
  int              vcnt[2]  = '{0, 0};
  int              fecnt[2] = '{0, 0};
  bit              sb_on = 1'b0;
  logic [31:0]     sbq_l[$];
  logic [31:0]     sbq_r[$];

  // Word = first SAMPLE_BITS bits received, zero-padded below if short.
  function automatic logic [31:0] word_of(int i);
    longint unsigned w;
    if (m_n[i] >= sbv[i]) w = m_all[i] >> (m_n[i] - sbv[i]);
    else                  w = m_all[i] << (sbv[i] - m_n[i]);
    w = w & ((64'd1 << sbv[i]) - 64'd1);
    return w[31:0];
  endfunction

  function automatic void model_clear(int i);
    m_recv[i] = 1'b0; m_wsd[i] = 1'b0; m_pend[i] = 1'b0; m_lost[i] = 1'b0;
    m_pl[i] = '0; m_l[i] = '0; m_r[i] = '0; m_all[i] = 0; m_n[i] = 0;
  endfunction

  function automatic void model_rise(int i, logic w, logic d);
    logic [31:0] word;
    if (!m_recv[i]) begin
      if (w != m_wsd[i]) begin
        m_recv[i] = 1'b1; m_all[i] = 0; m_n[i] = 0;
      end
    end else begin
      m_all[i] = (m_all[i] << 1) | 64'(d);
      m_n[i]++;
      if (w != m_wsd[i]) begin
        word    = word_of(i);
        m_fe[i] = (m_n[i] < sbv[i]);
        if (!m_wsd[i]) begin
          m_pl[i] = word; m_pend[i] = 1'b1;
        end else if (m_pend[i]) begin
          m_l[i] = m_pl[i]; m_r[i] = word; m_val[i] = 1'b1; m_pend[i] = 1'b0;
        end
        m_all[i] = 0; m_n[i] = 0;
      end
    end
    m_wsd[i]  = w;
    m_lost[i] = 1'b0;
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin
    rise_t cur;
    logic [31:0] el, er;
    for (int i = 0; i < 2; i++) model_clear(i);
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) begin m_val[i] = 1'b0; m_fe[i] = 1'b0; end
      if (!nrst) begin
        for (int i = 0; i < 2; i++) model_clear(i);
        rq.delete();
        in_rst = 1'b1;
      end else begin
        if (in_rst) begin last_clear = cyc; in_rst = 1'b0; end
        if (rq.size() > 0 && rq[0].c == cyc) begin
          cur = rq.pop_front();
          for (int i = 0; i < 2; i++) model_rise(i, cur.w, cur.d);
          last_clear = cyc;
        end else if (cyc == last_clear + T_OUT) begin
          for (int i = 0; i < 2; i++) begin
            m_lost[i] = 1'b1; m_recv[i] = 1'b0; m_pend[i] = 1'b0;
            m_all[i] = 0; m_n[i] = 0;
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        chk("sample_left",  i, sl[i], m_l[i]);
        chk("sample_right", i, sr[i], m_r[i]);
        chk("sample_valid", i, 32'(sv[i]),  32'(m_val[i]));
        chk("frame_error",  i, 32'(fe[i]),  32'(m_fe[i]));
        chk("busy",         i, 32'(bsy[i]), 32'(m_recv[i]));
        chk("sck_lost",     i, 32'(lst[i]), 32'(m_lost[i]));
        if (fe[i] === 1'b1) fecnt[i]++;
        if (sv[i] === 1'b1) begin
          vcnt[i]++;
          $display("[TB] cyc %0d dut%0d pair L=%h R=%h", cyc, i, sl[i], sr[i]);
        end
      end
      if (sb_on && sv[1] === 1'b1) begin
        chk("sb_pending", 1, 32'(sbq_l.size() > 0), 32'd1);
        if (sbq_l.size() > 0) begin
          el = sbq_l.pop_front();
          er = sbq_r.pop_front();
          chk("sb_left",  1, sl[1], el);
          chk("sb_right", 1, sr[1], er);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    sck = 1'b0;
    tick(n);
  endtask

  // Sends nb bits MSB first; WS = ch except on the final bit, where it takes
  // last_ws (standard one-bit-early WS change).
  task automatic send_bits(input logic ch, input logic [31:0] val, input int nb,
                           input logic last_ws, input int half);
    rise_t r;
    for (int k = nb - 1; k >= 0; k--) begin
      sck = 1'b0;
      ws  = (k == 0) ? last_ws : ch;
      sd  = val[k];
      tick(half);
      sck = 1'b1;
      r.c = cyc + 3; r.w = ws; r.d = sd;
      rq.push_back(r);
      tick(half);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nb,
                            input int half);
    send_bits(1'b0, l, nb, 1'b1, half);
    send_bits(1'b1, r, nb, 1'b0, half);
  endtask

  initial begin
    int v0, v1, f0, f1;
    logic [31:0] lw, rw;
    tick(3); #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_left", i, sl[i], 32'h0);
      chk("rst_right", i, sr[i], 32'h0);
      chk("rst_busy", i, 32'(bsy[i]), 32'h0);
      chk("rst_lost", i, 32'(lst[i]), 32'h0);
    end
    @(negedge clk);
    nrst = 1'b1;
    tick(2);

    // Standard stereo: first pair discarded, then one pair per frame.
    v0 = vcnt[0];
    repeat (4) send_frame(32'hA5C3, 32'h1234, 16, 4);
    idle(8); #2;
    chk("A_pairs", 0, 32'(vcnt[0] - v0), 32'd3);
    chk("A_left", 0, sl[0], 32'h0000A5C3);
    chk("A_right", 0, sr[0], 32'h00001234);
    chk("A_left24", 1, sl[1], 32'h00A5C300);
    chk("A_right24", 1, sr[1], 32'h00123400);

    // 32-bit slots: first SAMPLE_BITS bits kept, no frame error at 16 bits.
    v0 = vcnt[0]; f0 = fecnt[0];
    repeat (2) send_frame(32'hDEADBEEF, 32'h0BADF00D, 32, 4);
    idle(8); #2;
    chk("B_pairs", 0, 32'(vcnt[0] - v0), 32'd2);
    chk("B_ferr", 0, 32'(fecnt[0] - f0), 32'd0);
    chk("B_left", 0, sl[0], 32'h0000DEAD);
    chk("B_right", 0, sr[0], 32'h00000BAD);
    chk("B_left24", 1, sl[1], 32'h00DEADBE);
    chk("B_right24", 1, sr[1], 32'h000BADF0);

    // Short 12-bit left word.
    v0 = vcnt[0]; f0 = fecnt[0]; f1 = fecnt[1];
    send_bits(1'b0, 32'hABC, 12, 1'b1, 4);
    send_bits(1'b1, 32'h1234, 16, 1'b0, 4);
    idle(8); #2;
    chk("C_pairs", 0, 32'(vcnt[0] - v0), 32'd1);
    chk("C_ferr", 0, 32'(fecnt[0] - f0), 32'd1);
    chk("C_ferr24", 1, 32'(fecnt[1] - f1), 32'd2);
    chk("C_left", 0, sl[0], 32'h0000ABC0);
    chk("C_right", 0, sr[0], 32'h00001234);
    chk("C_left24", 1, sl[1], 32'h00ABC000);

    // SCK stops mid-word: link lost, outputs held; restart resyncs.
    v0 = vcnt[0];
    send_bits(1'b0, 32'h5A, 8, 1'b0, 4);
    idle(1100); #2;
    chk("D_lost", 0, 32'(lst[0]), 32'd1);
    chk("D_busy", 0, 32'(bsy[0]), 32'd0);
    chk("D_left_held", 0, sl[0], 32'h0000ABC0);
    chk("D_pairs_none", 0, 32'(vcnt[0] - v0), 32'd0);
    repeat (3) send_frame(32'hA5C3, 32'h1234, 16, 4);
    idle(8); #2;
    chk("D_lost_clear", 0, 32'(lst[0]), 32'd0);
    chk("D_pairs", 0, 32'(vcnt[0] - v0), 32'd2);

    // Reset pulsed mid-word: outputs clear at once, resync afterwards.
    send_bits(1'b0, 32'h15, 5, 1'b0, 4);
    idle(3);
    nrst = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("E_rst_left", i, sl[i], 32'h0);
      chk("E_rst_right", i, sr[i], 32'h0);
      chk("E_rst_busy", i, 32'(bsy[i]), 32'h0);
    end
    tick(3);
    nrst = 1'b1;
    idle(3);
    v0 = vcnt[0];
    repeat (3) send_frame(32'hA5C3, 32'h1234, 16, 4);
    idle(8); #2;
    chk("E_pairs", 0, 32'(vcnt[0] - v0), 32'd2);
    chk("E_left", 0, sl[0], 32'h0000A5C3);

    // Minimum SCK (2 high / 2 low), random 24-bit stereo.
    v1 = vcnt[1];
    sb_on = 1'b1;
    for (int f = 0; f < 100; f++) begin
      lw = $urandom() & 32'h00FFFFFF;
      rw = $urandom() & 32'h00FFFFFF;
      sbq_l.push_back(lw);
      sbq_r.push_back(rw);
      send_frame(lw, rw, 24, 2);
    end
    idle(8); #2;
    sb_on = 1'b0;
    chk("F_pairs", 1, 32'(vcnt[1] - v1), 32'd100);
    chk("F_sb_left_over", 1, 32'(sbq_l.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
